// File: rtl/cpu_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, shift FSM states and a count helper.
package cpu_uart_tx_pkg;

  localparam int TXDATA_OFF = 0;
  localparam int STATUS_OFF = 4;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // FIFO occupancy as firmware sees it: clipped to the 4-bit STATUS field
  function automatic logic [3:0] sat_count4(input int unsigned c);
    if (c > 15) return 4'hF;
    return c[3:0];
  endfunction

endpackage

// File: rtl/cpu_uart_tx_if.sv
// CPU data-memory bus as seen by a memory-mapped peripheral.
// The core drives the master side, the peripheral the slave side.
interface cpu_uart_tx_if #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_DATA_WIDTH = 32
);

  logic [DMEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DMEM_DATA_WIDTH-1:0] mem_wdata;
  logic                       mem_we;
  logic                       mem_re;
  logic [DMEM_DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/cpu_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Pointers wrap modulo
// DEPTH (power of two); count is one bit wider than the pointers so that
// full and empty are distinguishable. Reset flushes the contents.
module cpu_uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu_uart_tx.sv
// Memory-mapped UART transmitter on the CPU data-memory bus.
// Stores to TXDATA queue bytes in a FIFO; the shift FSM sends them 8N1,
// LSB first. STATUS exposes count/ovf/busy/empty/full for polling.
// Optional build macro: UART_PARITY_EN adds an even-parity bit after the data.
module cpu_uart_tx
  import cpu_uart_tx_pkg::*;
#(
  parameter int                         DMEM_ADDR_WIDTH = 12,
  parameter int                         DMEM_DATA_WIDTH = 32,
  parameter logic [DMEM_ADDR_WIDTH-1:0] BASE_ADDR       = 12'hF00,
  parameter int                         CLK_DIV         = 868,
  parameter int                         FIFO_DEPTH      = 8
) (
  input  logic         sysclk,
  input  logic         rst,
  cpu_uart_tx_if.slave bus,
  output logic         tx,
  output logic         tx_busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [DMEM_ADDR_WIDTH-1:0] TXDATA_ADDR = BASE_ADDR + DMEM_ADDR_WIDTH'(TXDATA_OFF);
  localparam logic [DMEM_ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + DMEM_ADDR_WIDTH'(STATUS_OFF);

  logic                       hit_txdata;
  logic                       hit_status;
  logic                       wr_txdata;
  logic                       push;
  logic                       pop;
  logic                       ovf;
  logic [7:0]                 fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [DMEM_DATA_WIDTH-1:0] status_word;
  logic                       unused_wdata;

  uart_state_t      state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [7:0]       shift, shift_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic             tx_q, tx_next;
  logic             wrap;
  logic             load;
`ifdef UART_PARITY_EN
  logic             parity, parity_next;
`endif

  assign hit_txdata   = (bus.mem_addr == TXDATA_ADDR);
  assign hit_status   = (bus.mem_addr == STATUS_ADDR);
  assign wr_txdata    = bus.mem_we && hit_txdata;
  assign push         = wr_txdata && !fifo_full;
  assign unused_wdata = ^bus.mem_wdata[DMEM_DATA_WIDTH-1:8];

  assign tx      = tx_q;
  assign tx_busy = (state != ST_IDLE) || !fifo_empty;
  assign wrap    = (baud_cnt == '0);

  cpu_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sysclk    (sysclk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.mem_wdata[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow: a store to a full FIFO sets it, any store to STATUS clears it
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      ovf <= 1'b1;
    end else if (bus.mem_we && hit_status) begin
      ovf <= 1'b0;
    end
  end

  // Assemble the STATUS word from the current (pre-edge) FIFO and line state
  always_comb begin
    status_word = '0;
    status_word[STAT_COUNT_LSB +: 4] = sat_count4(32'(fifo_count));
    status_word[STAT_OVF]   = ovf;
    status_word[STAT_BUSY]  = tx_busy;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
  end

  // Registered load data: updated only on a load strobe, held otherwise
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      bus.mem_rdata <= '0;
    end else if (bus.mem_re) begin
      bus.mem_rdata <= hit_status ? status_word : '0;
    end
  end

  // Shift FSM next-state logic; a frame is loaded from IDLE or straight out of STOP
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    shift_next    = shift;
    bit_idx_next  = bit_idx;
    tx_next       = tx_q;
    pop           = 1'b0;
    load          = 1'b0;
`ifdef UART_PARITY_EN
    parity_next   = parity;
`endif

    if (state != ST_IDLE) begin
      baud_cnt_next = wrap ? RELOAD : baud_cnt - 1'b1;
    end

    case (state)
      ST_IDLE: begin
        load = !fifo_empty;
      end
      ST_START: begin
        if (wrap) begin
          state_next   = ST_DATA;
          tx_next      = shift[0];
          shift_next   = {1'b0, shift[7:1]};
          bit_idx_next = 3'd0;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = ST_PARITY;
            tx_next    = parity;
`else
            state_next = ST_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift[0];
            shift_next   = {1'b0, shift[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (wrap) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (wrap) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase

    if (load) begin
      pop           = 1'b1;
      shift_next    = fifo_head;
      state_next    = ST_START;
      baud_cnt_next = RELOAD;
      tx_next       = 1'b0;
`ifdef UART_PARITY_EN
      parity_next   = ^fifo_head;
`endif
    end
  end

  // Shift FSM registers; reset forces the line idle and abandons any frame
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      tx_q     <= tx_next;
`ifdef UART_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_uart_tx.sv
// Testbench for cpu_uart_tx (CLK_DIV=4, FIFO_DEPTH=8, BASE_ADDR=12'hF00).
// A queue-based line model predicts tx, tx_busy and mem_rdata each cycle;
// directed checks pin the waveform with hand-computed literals.
// Honours UART_PARITY_EN in the same way as the design.
module tb_cpu_uart_tx;

  localparam int CLK_DIV = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  localparam logic [11:0] A_TXDATA = 12'hF00;
  localparam logic [11:0] A_STATUS = 12'hF04;

  logic sysclk = 1'b0;
  logic rst    = 1'b0;
  logic tx;
  logic tx_busy;

  cpu_uart_tx_if #(.DMEM_ADDR_WIDTH(12), .DMEM_DATA_WIDTH(32)) bus ();

  cpu_uart_tx #(
    .DMEM_ADDR_WIDTH (12),
    .DMEM_DATA_WIDTH (32),
    .BASE_ADDR       (12'hF00),
    .CLK_DIV         (CLK_DIV),
    .FIFO_DEPTH      (8)
  ) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_err = 0;

  // Line model state: bytes waiting, and the per-cycle tx values of the frame on the wire
  logic [7:0]  m_fifo [$];
  logic        m_line [$];
  logic        m_ovf     = 1'b0;
  logic        exp_tx    = 1'b1;
  logic        exp_busy  = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  int          pre_size;
  int          sat;
  logic        pre_busy;

  logic smp_tx   [0:127];
  logic smp_busy [0:127];

`ifdef UART_PARITY_EN
  logic grp_a5 [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  logic grp_a5 [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bus cycle starting just after a negedge; returns at the following negedge
  task automatic applyStimulus(input logic we, input logic re, input logic [11:0] addr,
                               input logic [31:0] data);
    bus.mem_we    = we;
    bus.mem_re    = re;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    @(negedge sysclk);
    bus.mem_we = 1'b0;
    bus.mem_re = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [11:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, addr, 32'h0);
    checkOutput(name, bus.mem_rdata, exp);
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      smp_tx[k]   = tx;
      smp_busy[k] = tx_busy;
      @(negedge sysclk);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (tx_busy && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput("drain_timeout", {31'b0, tx_busy}, 32'h0);
  endtask

  task automatic appendFrame(input logic [7:0] b);
    for (int c = 0; c < CLK_DIV; c++) m_line.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CLK_DIV; c++) m_line.push_back(b[i]);
`ifdef UART_PARITY_EN
    for (int c = 0; c < CLK_DIV; c++) m_line.push_back(^b);
`endif
    for (int c = 0; c < CLK_DIV; c++) m_line.push_back(1'b1);
  endtask

  // Model step per clock edge: status from pre-edge state, then line, then FIFO updates
  always @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf     = 1'b0;
      exp_tx    = 1'b1;
      exp_busy  = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      pre_size = m_fifo.size();
      pre_busy = (m_line.size() != 0) || (pre_size != 0);
      sat      = (pre_size > 15) ? 15 : pre_size;
      if (bus.mem_re) begin
        if (bus.mem_addr == A_STATUS)
          exp_rdata = {24'h0, sat[3:0], m_ovf, pre_busy, (pre_size == 0), (pre_size == 8)};
        else
          exp_rdata = 32'h0;
      end
      if (m_line.size() != 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && pre_size != 0) appendFrame(m_fifo.pop_front());
      if (bus.mem_we && bus.mem_addr == A_TXDATA) begin
        if (pre_size == 8) m_ovf = 1'b1;
        else m_fifo.push_back(bus.mem_wdata[7:0]);
      end
      if (bus.mem_we && bus.mem_addr == A_STATUS) m_ovf = 1'b0;
      exp_tx   = (m_line.size() != 0) ? m_line[0] : 1'b1;
      exp_busy = (m_line.size() != 0) || (m_fifo.size() != 0);
    end
  end

  // Every cycle out of reset, the DUT outputs must match the model
  always @(negedge sysclk) begin
    if (rst) begin
      checkOutput("model_tx", {31'b0, tx}, {31'b0, exp_tx});
      checkOutput("model_busy", {31'b0, tx_busy}, {31'b0, exp_busy});
      checkOutput("model_rdata", bus.mem_rdata, exp_rdata);
    end
  end

  // Directed sequence
  initial begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    repeat (3) @(negedge sysclk);
    checkOutput("reset_tx", {31'b0, tx}, 32'h1);
    checkOutput("reset_rdata", bus.mem_rdata, 32'h0);
    checkOutput("reset_busy", {31'b0, tx_busy}, 32'h0);
    rst = 1'b1;
    @(negedge sysclk);
    readCheck("reset_status", A_STATUS, 32'h02);

    // Single byte 0xA5: start low 4 cycles, bits 1,0,1,0,0,1,0,1, then stop
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h0000_00A5);
    capture(FRAME + 2);
    checkOutput("a5_before_start", {31'b0, smp_tx[0]}, 32'h1);
    for (int g = 0; g < NBITS; g++)
      for (int j = 0; j < CLK_DIV; j++)
        checkOutput($sformatf("a5_group%0d", g), {31'b0, smp_tx[1 + g*CLK_DIV + j]},
                    {31'b0, grp_a5[g]});
    checkOutput("a5_idle_after", {31'b0, smp_tx[FRAME + 1]}, 32'h1);
    checkOutput("a5_busy_last", {31'b0, smp_busy[FRAME]}, 32'h1);
    checkOutput("a5_busy_drop", {31'b0, smp_busy[FRAME + 1]}, 32'h0);

    // 0x55 then 0x0F back-to-back: second start directly follows the first stop
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h55);
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h0F);
    capture(2*FRAME + 1);
    checkOutput("b2b_55_bit0", {31'b0, smp_tx[4]}, 32'h1);
    checkOutput("b2b_55_bit1", {31'b0, smp_tx[8]}, 32'h0);
    checkOutput("b2b_stop1", {31'b0, smp_tx[FRAME - 1]}, 32'h1);
    checkOutput("b2b_start2", {31'b0, smp_tx[FRAME]}, 32'h0);
    checkOutput("b2b_0f_bit0", {31'b0, smp_tx[FRAME + 4]}, 32'h1);
    checkOutput("b2b_0f_bit4", {31'b0, smp_tx[FRAME + 20]}, 32'h0);
    checkOutput("b2b_busy_last", {31'b0, smp_busy[2*FRAME - 1]}, 32'h1);
    checkOutput("b2b_busy_drop", {31'b0, smp_busy[2*FRAME]}, 32'h0);

    // Overflow: fill FIFO while a frame is on the wire; 9th store is dropped
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h11);
    repeat (2) @(negedge sysclk);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h20 + i);
    // count 8, ovf, busy (frame in flight), full
    readCheck("ovf_status", A_STATUS, 32'h8D);
    applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
    readCheck("ovf_cleared", A_STATUS, 32'h85);
    waitIdle(9*FRAME + 50);
    readCheck("drained_status", A_STATUS, 32'h02);

    // Three bytes queued behind a frame in flight, then an out-of-window load
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h31);
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h32);
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h33);
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h34);
    readCheck("three_queued", A_STATUS, 32'h34);
    readCheck("outside_window", 12'hE00, 32'h0);
    readCheck("txdata_read", A_TXDATA, 32'h0);

    // Mid-DATA of 0x31 (bit1 = 0 on the wire): reset aborts and flushes
    repeat (5) @(negedge sysclk);
    checkOutput("pre_reset_tx", {31'b0, tx}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("abort_tx", {31'b0, tx}, 32'h1);
    checkOutput("abort_busy", {31'b0, tx_busy}, 32'h0);
    repeat (2) @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
    checkOutput("abort_rdata", bus.mem_rdata, 32'h0);
    readCheck("abort_status", A_STATUS, 32'h02);
    repeat (8) @(negedge sysclk);
    checkOutput("abort_line_idle", {31'b0, tx}, 32'h1);

`ifdef UART_PARITY_EN
    // 0x07 has three ones, so even parity puts a 1 on the wire; frame is 44 cycles
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h07);
    capture(FRAME + 2);
    checkOutput("par_bit7", {31'b0, smp_tx[33]}, 32'h0);
    for (int j = 0; j < CLK_DIV; j++)
      checkOutput("par_bit", {31'b0, smp_tx[37 + j]}, 32'h1);
    checkOutput("par_busy_last", {31'b0, smp_busy[44]}, 32'h1);
    checkOutput("par_busy_drop", {31'b0, smp_busy[45]}, 32'h0);
`endif

    repeat (2) @(negedge sysclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
